// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder driving one full-adder cell LSB-first.
// Optional SERIAL_ADDER_SUB_EN adds a sub port selecting a - b (cout=1 means no borrow).
module serial_adder_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] sa, sb;
  logic [CNT_W-1:0] cnt;
  logic carry, sub_en, fa_s, fa_c, last, take;
`ifdef SERIAL_ADDER_SUB_EN
  assign sub_en = sub;
`else
  assign sub_en = 1'b0;
`endif
  assign fa_s = sa[0] ^ sb[0] ^ carry;
  assign fa_c = (sa[0] & sb[0]) | (carry & (sa[0] ^ sb[0]));
  assign last = cnt == CNT_W'(WIDTH - 1);
  assign take = (state == IDLE) && start;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    busy = 1'b0;
    done = 1'b0;
    case (state)
      IDLE: state_nxt = start ? RUN : IDLE;
      RUN: begin
        busy = 1'b1;
        state_nxt = last ? DONE : RUN;
      end
      DONE: begin
        done = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
  // Subtract is a + ~b + 1, so the inversion and forced carry happen at capture.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sa <= '0;
      sb <= '0;
      carry <= 1'b0;
      cnt <= '0;
      sum <= '0;
      cout <= 1'b0;
    end else if (take) begin
      sa <= a;
      sb <= sub_en ? ~b : b;
      carry <= sub_en | cin;
      cnt <= '0;
    end else if (state == RUN) begin
      sum <= {fa_s, sum[WIDTH-1:1]};
      sa <= sa >> 1;
      sb <= sb >> 1;
      carry <= fa_c;
      cnt <= last ? '0 : cnt + 1'b1;
      if (last) cout <= fa_c;
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: scoreboard bench for serial_adder_ctrl (WIDTH=8).
// Define SERIAL_ADDER_SUB_EN for both bench and RTL to cover the subtract mode.
module tb_serial_adder_ctrl;
  localparam int W = 8;
  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, cin = 1'b0;
  logic [W-1:0] a = '0, b = '0, sum;
  logic busy, done, cout;
`ifdef SERIAL_ADDER_SUB_EN
  logic sub = 1'b0;
`endif
  int errors = 0, checks = 0;
  logic [W:0] q[$];

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  // Drives one start pulse (DUT assumed IDLE) and optionally queues the expected result.
  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                          input logic ts, input bit push);
    logic [W:0] e;
    @(negedge clk);
    a = ta;
    b = tb;
    cin = tc;
`ifdef SERIAL_ADDER_SUB_EN
    sub = ts;
`endif
    start = 1'b1;
    e = ts ? ({1'b0, ta} + {1'b0, ~tb} + (W+1)'(1)) : ({1'b0, ta} + {1'b0, tb} + (W+1)'(tc));
    if (push) q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits for done; cyc=0 on timeout, busy_n counts busy samples before done.
  task automatic wait_done(input int budget, output int cyc, output int busy_n);
    cyc = 0;
    busy_n = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (done) begin
        cyc = i;
        return;
      end
      if (busy) busy_n++;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({busy, done, cout, sum} !== '0)
      begin errors++; $display("FAIL reset_state: got busy=%b done=%b cout=%b sum=%h, want all 0", busy, done, cout, sum); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0)
      begin errors++; $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", busy, done); end
  endtask

  task automatic test_basic;
    int cyc, bn;
    logic [W:0] e;
    start_op(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b1);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_rise: got %b want 1", busy); end
    wait_done(W + 4, cyc, bn);
    checks++;
    if (cyc != W) begin errors++; $display("FAIL basic_latency: got %0d want %0d", cyc, W); end
    checks++;
    if (bn + 1 != W) begin errors++; $display("FAIL basic_busy_len: got %0d want %0d", bn + 1, W); end
    checks++;
    if (cyc != 0 && busy !== 1'b0) begin errors++; $display("FAIL basic_busy_in_done: got %b want 0", busy); end
    if (cyc != 0 && q.size() != 0) begin
      e = q.pop_front();
      checks++;
      if ({cout, sum} !== e) begin errors++; $display("FAIL basic_result: got %h want %h", {cout, sum}, e); end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b want 0", done); end
      repeat (3) @(negedge clk);
      checks++;
      if ({cout, sum} !== e) begin errors++; $display("FAIL basic_hold: got %h want %h", {cout, sum}, e); end
    end else begin
      errors++; $display("FAIL basic_timeout: got no done want done");
    end
  endtask

  task automatic test_vectors;
    logic [W-1:0] va[6], vb[6];
    logic vc[6];
    logic [W:0] e, prev;
    int cyc, bn;
    va[0] = 8'hFF; vb[0] = 8'h01; vc[0] = 1'b0;
    va[1] = 8'hFF; vb[1] = 8'hFF; vc[1] = 1'b1;
    for (int i = 2; i < 6; i++) begin
      va[i] = W'($urandom); vb[i] = W'($urandom); vc[i] = 1'($urandom);
    end
    for (int i = 0; i < 6; i++) begin
      prev = {cout, sum};
      start_op(va[i], vb[i], vc[i], 1'b0, 1'b1);
      checks++;
      if ({cout, sum} !== prev) begin errors++; $display("FAIL vec%0d_hold_until_run: got %h want %h", i, {cout, sum}, prev); end
      wait_done(W + 4, cyc, bn);
      checks++;
      if (cyc != W || q.size() == 0) begin
        errors++; $display("FAIL vec%0d_latency: got %0d want %0d", i, cyc, W);
        if (q.size() != 0) void'(q.pop_front());
      end else begin
        e = q.pop_front();
        checks++;
        if ({cout, sum} !== e) begin errors++; $display("FAIL vec%0d_result: got %h want %h", i, {cout, sum}, e); end
      end
    end
  endtask

  task automatic test_ignore_start;
    int cyc, bn, stray;
    logic [W:0] e;
    start_op(8'h12, 8'h34, 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    a = 8'hFF;
    b = 8'hFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(W + 4, cyc, bn);
    checks++;
    if (cyc == 0 || q.size() == 0) begin
      errors++; $display("FAIL ignore_timeout: got no done want done");
    end else begin
      e = q.pop_front();
      if ({cout, sum} !== e) begin errors++; $display("FAIL ignore_result: got %h want %h", {cout, sum}, e); end
    end
    stray = 0;
    repeat (W + 4) begin
      @(negedge clk);
      if (busy || done) stray++;
    end
    checks++;
    if (stray != 0) begin errors++; $display("FAIL ignore_no_second_op: got %0d busy/done cycles want 0", stray); end
  endtask

  task automatic test_reset_abort;
    int cyc, bn, stray;
    logic [W:0] e;
    start_op(8'hAA, 8'h55, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, cout, sum} !== '0)
      begin errors++; $display("FAIL abort_outputs: got busy=%b done=%b cout=%b sum=%h want all 0", busy, done, cout, sum); end
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    repeat (W + 3) begin
      @(negedge clk);
      if (busy || done) stray++;
    end
    checks++;
    if (stray != 0) begin errors++; $display("FAIL abort_no_done: got %0d busy/done cycles want 0", stray); end
    start_op(8'hAA, 8'h55, 1'b0, 1'b0, 1'b1);
    wait_done(W + 4, cyc, bn);
    checks++;
    if (cyc == 0 || q.size() == 0) begin
      errors++; $display("FAIL abort_restart_timeout: got no done want done");
    end else begin
      e = q.pop_front();
      if ({cout, sum} !== e) begin errors++; $display("FAIL abort_restart_result: got %h want %h", {cout, sum}, e); end
    end
  endtask

  task automatic test_back_to_back;
    int t, last_t, ndone;
    logic [W:0] e;
    @(negedge clk);
    a = 8'h77;
    b = 8'h99;
    cin = 1'b1;
    start = 1'b1;
    repeat (3) q.push_back({1'b0, 8'h77} + {1'b0, 8'h99} + (W+1)'(1));
    t = 0;
    last_t = -1;
    ndone = 0;
    while (ndone < 3 && t < 4 * (W + 2) + 10) begin
      @(negedge clk);
      t++;
      if (done) begin
        ndone++;
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL b2b_extra_done: got done with empty scoreboard");
        end else begin
          e = q.pop_front();
          if ({cout, sum} !== e) begin errors++; $display("FAIL b2b_result%0d: got %h want %h", ndone, {cout, sum}, e); end
        end
        if (last_t >= 0) begin
          checks++;
          if (t - last_t != W + 2) begin errors++; $display("FAIL b2b_spacing: got %0d want %0d", t - last_t, W + 2); end
        end
        last_t = t;
        if (ndone == 3) start = 1'b0;
      end
    end
    start = 1'b0;
    checks++;
    if (ndone != 3) begin errors++; $display("FAIL b2b_count: got %0d want 3", ndone); end
    repeat (W + 4) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || q.size() != 0)
      begin errors++; $display("FAIL b2b_drain: got busy=%b pending=%0d want 0 0", busy, q.size()); end
    q.delete();
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub;
    logic [W-1:0] va[3], vb[3];
    logic [W:0] e;
    int cyc, bn;
    va[0] = 8'h10; vb[0] = 8'h01;
    va[1] = 8'h00; vb[1] = 8'h01;
    va[2] = 8'h80; vb[2] = 8'h80;
    for (int i = 0; i < 3; i++) begin
      start_op(va[i], vb[i], 1'b0, 1'b1, 1'b1);
      wait_done(W + 4, cyc, bn);
      checks++;
      if (cyc == 0 || q.size() == 0) begin
        errors++; $display("FAIL sub%0d_timeout: got no done want done", i);
      end else begin
        e = q.pop_front();
        if ({cout, sum} !== e) begin errors++; $display("FAIL sub%0d_result: got %h want %h", i, {cout, sum}, e); end
      end
    end
    sub = 1'b0;
  endtask
`endif

  initial begin
    #1 rst_n = 1'b0;
    test_reset;
    test_basic;
    test_vectors;
    test_ignore_start;
    test_reset_abort;
    test_back_to_back;
`ifdef SERIAL_ADDER_SUB_EN
    test_sub;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
